up_count_ctrl: RTL
==================

# up_count_ctrl

Sequencing controller for the 4-bit enable/clear up-counter datapath. It sits between the control plane and the counter and turns a start/pause/abort command interface into cycle-accurate `cnt_en` / `cnt_clr` strobes.

- A programmable prescaler sets the counter tick rate.
- A terminal value ends each count period.
- One-shot or periodic mode selects whether counting stops or restarts at the terminal value.
- The block reports `busy`, `paused`, a `done` pulse and a completed-period tally.

## Interface
Parameters:
- `WIDTH`, 4, width of the controlled counter and of `term`
- `PRE_W`, 4, width of the prescale value
- `PER_W`, 8, width of the completed-period tally

Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge
- `rst` input 1: synchronous, active-high reset
- `start` input 1: in IDLE, latch config and begin; in PAUSE, resume
- `pause` input 1: in RUN, freeze counting
- `abort` input 1: in RUN/PAUSE, terminate and clear the counter, no `done`
- `periodic` input 1: latched at start; 1 = auto-restart, 0 = one-shot
- `term` input WIDTH: terminal count value, latched at start
- `prescale` input PRE_W: tick every `prescale`+1 RUN cycles, latched at start
- `count` input WIDTH: current value from the controlled counter
- `cnt_en` output 1: counter increment enable (combinational)
- `cnt_clr` output 1: counter clear (combinational)
- `busy` output 1: state != IDLE (registered state decode)
- `paused` output 1: state == PAUSE
- `done` output 1: one-cycle registered pulse per completed period
- `periods` output PER_W: completed periods since last start, wraps mod 2^PER_W

## Operation
- States: IDLE, RUN, PAUSE. Internal registers:
  - `term_q`, `pre_q`, `per_q`: latched config
  - `pre_cnt` (PRE_W): prescaler count
  - `periods`
- `tick` = (state==RUN) && (`pre_cnt` == `pre_q`) && !`pause` && !`abort`.
- `expire` = `tick` && (`count` == `term_q`).
- IDLE:
  - `start` && !`abort`: latch `term`/`prescale`/`periodic`, `pre_cnt`<=0, `periods`<=0, `cnt_clr`=1, then go to RUN.
  - `pause` and `abort` are ignored.
- RUN:
  - `abort`: `cnt_clr`=1, then IDLE.
  - Else `pause`: go to PAUSE; `pre_cnt` holds.
  - Else `pre_cnt` increments, resetting to 0 on `tick`.
  - `tick` && !`expire`: `cnt_en`=1.
  - `expire`: `cnt_en`=0, `cnt_clr`=1, `done`<=1 and `periods`<=`periods`+1. Then one-shot goes to IDLE; periodic stays in RUN.
  - `start` is ignored.
- PAUSE:
  - `abort`: `cnt_clr`=1, then IDLE.
  - Else `start`: go to RUN; `pre_cnt`, `count` and config are preserved.
  - No strobes are issued.
- Priority: `rst` > `abort` > `pause` > `start` > `tick`/`expire`.
- `cnt_clr` is also asserted whenever `rst`=1, so the counter is cleared with the controller.
- `cnt_en` and `cnt_clr` are never both 1.
- Changes to the config inputs after start have no effect until the next start from IDLE.
- `term_q`=0: the first tick expires immediately, giving a period of `prescale`+1 cycles.

## Timing
- Reset values: IDLE, `busy`=0, `paused`=0, `done`=0, `periods`=0, `cnt_en`=0, `pre_cnt`=0. `cnt_clr`=1 during reset.
- Start accepted at edge E0, so RUN begins the cycle after E0. The k-th tick occurs k*(P+1) cycles after the start cycle, where P=`pre_q` and T=`term_q`.
- One-shot: `expire` occurs on tick T+1, and `done` is high exactly (T+1)*(P+1)+1 cycles after the start cycle. `busy` falls in the same cycle `done` rises.
- Periodic: `done` pulses every (T+1)*(P+1) cycles. The counter runs 0..T, then clears and restarts at 0 with no dead cycle.
- Each cycle spent in PAUSE delays all subsequent events by exactly one cycle.
- `rst` mid-operation: IDLE on the next edge, `periods`=0, counter cleared, no `done`.

## Test plan
- Reset then one-shot, `term`=3, `prescale`=0, start at cycle 0: `cnt_en` high cycles 1–3, `cnt_clr` at cycle 4, `done`=1 at cycle 5, `busy`=0 at cycle 5, `periods`=1.
- Periodic, `term`=2, `prescale`=1: `count` sequence 0,0,1,1,2,2,0 and so on; `done` every 6 cycles; after 4 periods `periods`=4; `busy` stays 1.
- One-shot `term`=5, `prescale`=0, pause for 3 cycles when `count`=2, then resume with `start`: `count` holds at 2 and `paused`=1; `done` arrives 3 cycles later than the unpaused run (cycle 10 instead of 7).
- `abort` at `count`=3 in RUN, and separately in PAUSE: `cnt_clr`=1 that cycle, IDLE next, `count`=0, `done` never asserted.
- Simultaneous events:
  - `start`+`abort` in IDLE: stays IDLE.
  - `pause` on a tick cycle: no `cnt_en`, goes to PAUSE.
  - `start` in RUN with new `term`: ignored, old period is kept.
- `term`=0, `prescale`=3: `done` every 4 cycles in periodic mode. `rst` asserted mid-period gives all reset values on the next edge.

Source files
------------

// File: rtl/up_count_ctrl.sv
// up_count_ctrl: start/pause/abort sequencer driving cnt_en/cnt_clr for an up-counter with prescaled ticks.
module up_count_ctrl #(
    parameter int WIDTH = 4,
    parameter int PRE_W = 4,
    parameter int PER_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             periodic,
    input  logic [WIDTH-1:0] term,
    input  logic [PRE_W-1:0] prescale,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic [PER_W-1:0] periods
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] term_q;
    logic [PRE_W-1:0] pre_q, pre_cnt;
    logic per_q, go, tick, expire;
    always_comb begin
        go       = state == IDLE && start && !abort;
        tick     = state == RUN && pre_cnt == pre_q && !pause && !abort;
        expire   = tick && count == term_q;
        cnt_en   = tick && !expire && !rst;
        cnt_clr  = rst || go || (state != IDLE && abort) || expire;
        state_nx = state;
        case (state)
            IDLE:    state_nx = go ? RUN : IDLE;
            RUN:     state_nx = abort ? IDLE : pause ? PAUSE : (expire && !per_q) ? IDLE : RUN;
            PAUSE:   state_nx = abort ? IDLE : start ? RUN : PAUSE;
            default: state_nx = IDLE;
        endcase
    end
    assign busy   = state != IDLE;
    assign paused = state == PAUSE;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // pre_cnt only advances on RUN cycles that are not paused or aborted
    always_ff @(posedge clk) begin
        if (rst) begin
            term_q  <= '0;
            pre_q   <= '0;
            per_q   <= 1'b0;
            pre_cnt <= '0;
            periods <= '0;
            done    <= 1'b0;
        end else begin
            done <= expire;
            if (go) begin
                term_q  <= term;
                pre_q   <= prescale;
                per_q   <= periodic;
                pre_cnt <= '0;
                periods <= '0;
            end else begin
                if (state == RUN && !abort && !pause) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                if (expire) periods <= periods + 1'b1;
            end
        end
    end
endmodule
